reg_scoreboard: RTL

- Producer-side register status tracker for the in-order issue stage.
- On each dispatched instruction with a register write, marks the destination busy and records its producer tag. Writeback clears that entry.
- Reports busy state and producer tag for decode's rs1/rs2, and stalls dispatch on RAW or WAW hazards against in-flight writers.
- Sits between IDU dispatch and the writeback bus. The EXU/MEM operand-forwarding select logic consumes its busy/tag outputs.

---
 rtl/reg_scoreboard.sv | 107 ++++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writers per architectural register.
// Optional stall counter output enabled by defining SB_PERF_CNT_EN.
module reg_scoreboard #(
  parameter int NREG  = 32,
  parameter int TAG_W = 4,
  localparam int RW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [RW-1:0]    disp_rs1,
  input  logic [RW-1:0]    disp_rs2,
  input  logic             disp_rs1_en,
  input  logic             disp_rs2_en,
  input  logic [RW-1:0]    disp_rd,
  input  logic             disp_R_Wen,
  input  logic [TAG_W-1:0] disp_tag,
  output logic             rs1_busy,
  output logic [TAG_W-1:0] rs1_tag,
  output logic             rs2_busy,
  output logic [TAG_W-1:0] rs2_tag,
  input  logic             wb_valid,
  input  logic [RW-1:0]    wb_rd,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic             flush,
  output logic [NREG-1:0]  busy_vec
`ifdef SB_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  logic [NREG-1:0]  busy;
  logic [TAG_W-1:0] tag [NREG];

  logic wb_hit1;
  logic wb_hit2;
  logic wb_hitd;
  logic rd_pend;
  logic fire;
  logic set_rd;
  logic clr_wb;

  // A writeback matching the current owner's tag makes the register
  // look free this cycle already.
  always_comb begin
    wb_hit1 = wb_valid && (wb_rd == disp_rs1)
           && (wb_tag == tag[disp_rs1]);
    wb_hit2 = wb_valid && (wb_rd == disp_rs2)
           && (wb_tag == tag[disp_rs2]);
    wb_hitd = wb_valid && (wb_rd == disp_rd)
           && (wb_tag == tag[disp_rd]);

    rs1_busy = disp_rs1_en && (disp_rs1 != '0)
            && busy[disp_rs1] && !wb_hit1;
    rs2_busy = disp_rs2_en && (disp_rs2 != '0)
            && busy[disp_rs2] && !wb_hit2;
    rs1_tag  = rs1_busy ? tag[disp_rs1] : '0;
    rs2_tag  = rs2_busy ? tag[disp_rs2] : '0;

    rd_pend  = disp_R_Wen && (disp_rd != '0)
            && busy[disp_rd] && !wb_hitd;

    disp_ready = !flush && !rs1_busy
              && !rs2_busy && !rd_pend;

    fire   = disp_valid && disp_ready;
    set_rd = fire && disp_R_Wen && (disp_rd != '0);
    clr_wb = wb_valid && (wb_rd != '0)
          && busy[wb_rd] && (tag[wb_rd] == wb_tag);
  end

  // Set follows clear so a same-register dispatch keeps the new owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      for (int i = 0; i < NREG; i++) begin
        tag[i] <= '0;
      end
    end else if (flush) begin
      busy <= '0;
    end else begin
      if (clr_wb) begin
        busy[wb_rd] <= 1'b0;
      end
      if (set_rd) begin
        busy[disp_rd] <= 1'b1;
        tag[disp_rd]  <= disp_tag;
      end
    end
  end

  assign busy_vec = busy;

`ifdef SB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (disp_valid && !disp_ready && !flush
                 && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
